// File: rtl/counter_if.sv
// Control/status bundle for counter_updown_mod.
// The master drives the controls; the slave (the counter) drives out/tc/ovf.
interface counter_if #(
  parameter int WIDTH = 4
);
  logic             en;
  logic             clr;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             up_dn;
  logic             sat_mode;
  logic [WIDTH-1:0] modulo;
  logic             clr_flags;
  logic [WIDTH-1:0] out;
  logic             tc;
  logic             ovf;

  modport master (
    output en, clr, load, load_val, up_dn, sat_mode, modulo, clr_flags,
    input  out, tc, ovf
  );

  modport slave (
    input  en, clr, load, load_val, up_dn, sat_mode, modulo, clr_flags,
    output out, tc, ovf
  );
endinterface

// File: rtl/counter_updown_mod.sv
// Up/down modulo counter with runtime modulo, load, clear, wrap/saturate, tc pulse and sticky ovf.
// Optional step prescaler enabled by defining COUNTER_PRESCALE_EN.
module counter_updown_mod #(
  parameter int WIDTH     = 4,
  parameter int RESET_VAL = 0,
  parameter int PRESCALE  = 4
) (
  input  logic      clk,
  input  logic      rst_n,
  counter_if.slave  bus
);

  if (WIDTH < 2 || RESET_VAL < 0 || RESET_VAL >= (2 ** WIDTH) || PRESCALE < 1) begin : g_bad_params
    $error("counter_updown_mod: illegal parameter combination");
  end

  localparam logic [WIDTH-1:0] RST_V = WIDTH'(RESET_VAL);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;
  logic [WIDTH-1:0] limit;
  logic             tc_q;
  logic             ovf_q;
  logic             ovf_d;
  logic             step;
  logic             term;

  // modulo==0 selects the full range, so limit becomes all ones.
  assign limit = (bus.modulo == '0) ? '1 : bus.modulo - 1'b1;

`ifdef COUNTER_PRESCALE_EN
  localparam int            PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] pre_q;

  // Phase freezes while en is low; clr/load restart it so the next step is a full period away.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q <= '0;
    end else if (bus.clr || bus.load) begin
      pre_q <= '0;
    end else if (bus.en) begin
      pre_q <= (pre_q == PRE_LAST) ? '0 : pre_q + 1'b1;
    end
  end

  assign step = bus.en && (pre_q == PRE_LAST);
`else
  assign step = bus.en;
`endif

  // NOTE: every output of a combinational block gets a default first, otherwise paths that skip an assignment infer latches.
  always_comb begin
    cnt_d = cnt_q;
    term  = 1'b0;
    if (bus.clr) begin
      cnt_d = RST_V;
    end else if (bus.load) begin
      cnt_d = bus.load_val;
    end else if (step) begin
      if (bus.up_dn) begin
        // >= so a loaded value above the limit terminates on its next up step.
        if (cnt_q >= limit) begin
          term  = 1'b1;
          cnt_d = bus.sat_mode ? limit : '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end else begin
        if (cnt_q == '0) begin
          term  = 1'b1;
          cnt_d = bus.sat_mode ? '0 : limit;
        end else if (cnt_q > limit) begin
          cnt_d = limit;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
    end
  end

  // clr_flags wins over a same-cycle terminal step.
  always_comb begin
    ovf_d = ovf_q;
    if (bus.clr || bus.clr_flags) begin
      ovf_d = 1'b0;
    end else if (term) begin
      ovf_d = 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= RST_V;
      tc_q  <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tc_q  <= term;
      ovf_q <= ovf_d;
    end
  end

  assign bus.out = cnt_q;
  assign bus.tc  = tc_q;
  assign bus.ovf = ovf_q;

endmodule

// File: tb/tb_counter_updown_mod.sv
// Directed self-checking bench for counter_updown_mod (WIDTH=4, RESET_VAL=0).
// The prescaler section follows COUNTER_PRESCALE_EN like the design does.
module tb_counter_updown_mod;

  localparam int WIDTH = 4;

  logic clk;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  counter_if #(.WIDTH(WIDTH)) bus ();

  counter_updown_mod #(
    .WIDTH    (WIDTH),
    .RESET_VAL(0),
    .PRESCALE (4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one clock and sample 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.en        = 1'b0;
    bus.clr       = 1'b0;
    bus.load      = 1'b0;
    bus.load_val  = '0;
    bus.up_dn     = 1'b1;
    bus.sat_mode  = 1'b0;
    bus.modulo    = '0;
    bus.clr_flags = 1'b0;

    #12;
    check("reset_out", 32'(bus.out), 0);
    check("reset_tc",  32'(bus.tc),  0);
    check("reset_ovf", 32'(bus.ovf), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: modulo 10, up, wrap, 12 steps from 0.
    bus.modulo = 4'd10;
    bus.up_dn  = 1'b1;
    bus.en     = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      check($sformatf("t1_out_%0d", i), 32'(bus.out), 32'(i % 10));
      check($sformatf("t1_tc_%0d", i),  32'(bus.tc),  32'(i == 10));
    end
    bus.en = 1'b0;
    check("t1_ovf", 32'(bus.ovf), 1);
    tick();
    check("t1_idle_out", 32'(bus.out), 2);
    check("t1_idle_tc",  32'(bus.tc),  0);

    // 2: full range, down, saturate from 2.
    bus.clr_flags = 1'b1;
    tick();
    check("t2_preclr_ovf", 32'(bus.ovf), 0);
    bus.clr_flags = 1'b0;
    bus.modulo    = 4'd0;
    bus.up_dn     = 1'b0;
    bus.sat_mode  = 1'b1;
    bus.load      = 1'b1;
    bus.load_val  = 4'd2;
    tick();
    check("t2_load_out", 32'(bus.out), 2);
    bus.load = 1'b0;
    bus.en   = 1'b1;
    tick(); check("t2_s1_out", 32'(bus.out), 1); check("t2_s1_tc", 32'(bus.tc), 0);
    tick(); check("t2_s2_out", 32'(bus.out), 0); check("t2_s2_tc", 32'(bus.tc), 0);
    tick(); check("t2_s3_out", 32'(bus.out), 0); check("t2_s3_tc", 32'(bus.tc), 1);
    tick(); check("t2_s4_out", 32'(bus.out), 0); check("t2_s4_tc", 32'(bus.tc), 1);
    bus.en = 1'b0;
    check("t2_ovf_set", 32'(bus.ovf), 1);
    bus.clr_flags = 1'b1;
    tick();
    check("t2_clrflags_ovf", 32'(bus.ovf), 0);
    check("t2_clrflags_out", 32'(bus.out), 0);
    // Terminal step and clr_flags together: tc pulses, ovf stays clear.
    bus.en = 1'b1;
    tick();
    check("t2_override_tc",  32'(bus.tc),  1);
    check("t2_override_ovf", 32'(bus.ovf), 0);
    bus.en        = 1'b0;
    bus.clr_flags = 1'b0;

    // 3: load above the limit, then step up and down.
    bus.modulo   = 4'd10;
    bus.up_dn    = 1'b1;
    bus.sat_mode = 1'b0;
    bus.load     = 1'b1;
    bus.load_val = 4'd13;
    tick();
    check("t3_load_out", 32'(bus.out), 13);
    check("t3_load_tc",  32'(bus.tc),  0);
    bus.load = 1'b0;
    bus.en   = 1'b1;
    tick();
    check("t3_up_out", 32'(bus.out), 0);
    check("t3_up_tc",  32'(bus.tc),  1);
    check("t3_up_ovf", 32'(bus.ovf), 1);
    bus.en   = 1'b0;
    bus.load = 1'b1;
    tick();
    bus.load  = 1'b0;
    bus.up_dn = 1'b0;
    bus.en    = 1'b1;
    tick();
    check("t3_dn_out", 32'(bus.out), 9);
    check("t3_dn_tc",  32'(bus.tc),  0);
    tick();
    check("t3_dn2_out", 32'(bus.out), 8);
    bus.en = 1'b0;

    // 4: clr beats load; then async reset in mid-cycle.
    bus.clr      = 1'b1;
    bus.load     = 1'b1;
    bus.load_val = 4'd5;
    tick();
    check("t4_clr_out", 32'(bus.out), 0);
    check("t4_clr_ovf", 32'(bus.ovf), 0);
    check("t4_clr_tc",  32'(bus.tc),  0);
    bus.clr      = 1'b0;
    bus.load_val = 4'd9;
    tick();
    bus.load     = 1'b0;
    bus.up_dn    = 1'b1;
    bus.sat_mode = 1'b1;
    bus.en       = 1'b1;
    tick();
    check("t4_sat_out", 32'(bus.out), 9);
    check("t4_sat_tc",  32'(bus.tc),  1);
    check("t4_sat_ovf", 32'(bus.ovf), 1);
    bus.en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("t4_arst_out", 32'(bus.out), 0);
    check("t4_arst_tc",  32'(bus.tc),  0);
    check("t4_arst_ovf", 32'(bus.ovf), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // 6: alternate direction at modulo 5; 4 is the limit, so the up step from it is terminal too.
    bus.modulo   = 4'd5;
    bus.sat_mode = 1'b0;
    bus.en       = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.up_dn = (i % 2 == 1);
      tick();
      check($sformatf("t6_out_%0d", i), 32'(bus.out), (i % 2 == 0) ? 4 : 0);
      check($sformatf("t6_tc_%0d", i),  32'(bus.tc),  1);
    end
    bus.en = 1'b0;

    // 5: step rate with and without the prescaler.
    bus.clr = 1'b1;
    tick();
    bus.clr    = 1'b0;
    bus.modulo = 4'd0;
    bus.up_dn  = 1'b1;
    bus.en     = 1'b1;
    repeat (8) tick();
`ifdef COUNTER_PRESCALE_EN
    check("t5_8clk_out", 32'(bus.out), 2);
    repeat (2) tick();
    check("t5_phase_out", 32'(bus.out), 2);
    bus.en = 1'b0;
    repeat (3) tick();
    bus.en = 1'b1;
    tick();
    check("t5_resume1_out", 32'(bus.out), 2);
    tick();
    check("t5_resume2_out", 32'(bus.out), 3);
`else
    check("t5_8clk_out", 32'(bus.out), 8);
    bus.en = 1'b0;
    repeat (3) tick();
    check("t5_hold_out", 32'(bus.out), 8);
`endif
    bus.en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
